// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: one-hot grant via lowest-set-bit isolation, held until the owner
// releases it or a hold timeout expires, with a sticky one-hot self-check.
module rr_onehot_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW     = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req,
  input  logic           i_done,
  output logic [N-1:0]   o_gnt,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_timeout,
  output logic           o_onehot_err
);

  localparam int unsigned CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [N-1:0] One = N'(1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [N-1:0]   r_mask, w_mask_nxt;
  logic [CW-1:0]  r_hold_cnt, w_hold_cnt_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic           r_onehot_err, w_onehot_err_nxt;

  logic [N-1:0]   w_req_masked;
  logic [N-1:0]   w_win;
  logic [IDW-1:0] w_win_id;
  logic           w_owner_req;
  logic           w_hold_expired;
  logic           w_release;

  // Masked set favours requesters above the last owner; an empty set wraps to bit 0 side.
  always_comb begin
    w_req_masked = i_req & r_mask;
    if (|w_req_masked) begin
      w_win = w_req_masked & (~w_req_masked + One);
    end else begin
      w_win = i_req & (~i_req + One);
    end
  end

  always_comb begin
    w_win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win[i]) begin
        w_win_id = IDW'(i);
      end
    end
  end

  assign w_owner_req    = i_req[r_gnt_id];
  assign w_hold_expired = (MAX_HOLD != 0) && (r_hold_cnt == HoldLast);
  assign w_release      = i_done || !w_owner_req || w_hold_expired;

  always_comb begin
    w_state_nxt      = r_state;
    w_gnt_nxt        = r_gnt;
    w_gnt_id_nxt     = r_gnt_id;
    w_mask_nxt       = r_mask;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_timeout_nxt    = 1'b0;
    w_onehot_err_nxt = r_onehot_err | ((|r_gnt) && (|(r_gnt & (r_gnt - One))));
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          w_gnt_nxt      = w_win;
          w_gnt_id_nxt   = w_win_id;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = StGrant;
        end
      end
      StGrant: begin
        if (w_release) begin
          w_state_nxt   = StIdle;
          w_gnt_nxt     = '0;
          w_mask_nxt    = ~(r_gnt | (r_gnt - One));
          // Timeout only when neither done nor a dropped request explains the release.
          w_timeout_nxt = !i_done && w_owner_req;
        end else if (r_hold_cnt != HoldLast) begin
          w_hold_cnt_nxt = r_hold_cnt + CW'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_gnt        <= '0;
      r_gnt_id     <= '0;
      r_mask       <= '1;
      r_hold_cnt   <= '0;
      r_timeout    <= 1'b0;
      r_onehot_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_gnt_id     <= w_gnt_id_nxt;
      r_mask       <= w_mask_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
      r_onehot_err <= w_onehot_err_nxt;
    end
  end

  assign o_gnt        = r_gnt;
  assign o_gnt_valid  = (r_state == StGrant);
  assign o_gnt_id     = r_gnt_id;
  assign o_timeout    = r_timeout;
  assign o_onehot_err = r_onehot_err;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=4, MAX_HOLD=8) plus a model-checked random soak.
module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;
  logic       onehot_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] rot_exp [8] = '{4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};

  rr_onehot_arbiter #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (req),
    .i_done       (done),
    .o_gnt        (gnt),
    .o_gnt_valid  (gnt_valid),
    .o_gnt_id     (gnt_id),
    .o_timeout    (timeout),
    .o_onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    #12;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0 || onehot_err !== 1'b0
        || gnt_id !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: gnt=%b valid=%b to=%b err=%b id=%0d, want 0000 0 0 0 0",
               gnt, gnt_valid, timeout, onehot_err, gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_valid !== 1'b1 || gnt_id !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_first_grant: gnt=%b valid=%b id=%0d, want 0001 1 0",
               gnt, gnt_valid, gnt_id);
    end
  endtask

  task automatic test_rotation();
    for (int k = 0; k < 8; k++) begin
      done = (k % 2 == 0);
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt !== rot_exp[k] || timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL rotation[%0d]: gnt=%b to=%b, want %b 0", k, gnt, timeout, rot_exp[k]);
      end
    end
  endtask

  task automatic test_masked_skip();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL skip_setup: gnt=%b, want 0010", gnt);
    end
    req  = 4'b0011;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL skip_release: gnt=%b valid=%b, want 0000 0", gnt, gnt_valid);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      n_errors++;
      $display("FAIL skip_fallback: gnt=%b id=%0d, want 0001 0", gnt, gnt_id);
    end
    req  = 4'b1001;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_errors++;
      $display("FAIL skip_masked: gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
    end
  endtask

  task automatic test_timeout();
    int held;
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_release: gnt=%b to=%b, want 0000 0", gnt, timeout);
    end
    held = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt === 4'b0100 && timeout === 1'b0) held++;
    end
    n_checks++;
    if (held != 8) begin
      n_errors++;
      $display("FAIL timeout_hold: held %0d cycles, want 8", held);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_pulse: gnt=%b to=%b, want 0000 1", gnt, timeout);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_regrant: gnt=%b to=%b, want 0100 0", gnt, timeout);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_errors++;
      $display("FAIL sim_hold7: gnt=%b, want 0100", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_done_wins: gnt=%b to=%b, want 0000 0", gnt, timeout);
    end
    tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_owner_drop: gnt=%b to=%b, want 0000 0", gnt, timeout);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL sim_idle_done: gnt=%b valid=%b, want 0000 0", gnt, gnt_valid);
    end
    req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_errors++;
      $display("FAIL sim_wrap_fallback: gnt=%b id=%0d, want 0010 1", gnt, gnt_id);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_errors++;
      $display("FAIL async_setup: gnt=%b id=%0d, want 1000 3", gnt, gnt_id);
    end
    req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
      n_errors++;
      $display("FAIL async_drop: gnt=%b valid=%b id=%0d, want 0000 0 0", gnt, gnt_valid, gnt_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL async_mask_reset: gnt=%b, want 0001", gnt);
    end
  endtask

  task automatic test_soak();
    int m_owner, m_start, m_hold, pick, bad, j;
    logic m_to;
    logic [3:0] m_gnt;
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    #1;
    @(negedge clk);
    rst_n   = 1'b1;
    m_owner = -1;
    m_start = 0;
    m_hold  = 0;
    m_to    = 1'b0;
    bad     = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 3);
        req[j] = ~req[j];
      end
      done = ($urandom_range(0, 9) == 0);
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (req != 4'b0000) begin
          pick = -1;
          for (int i = m_start; i < 4; i++) if (pick < 0 && req[i]) pick = i;
          for (int i = 0; i < 4; i++) if (pick < 0 && req[i]) pick = i;
          m_owner = pick;
          m_hold  = 0;
        end
      end else if (done || !req[m_owner]) begin
        m_start = m_owner + 1;
        m_owner = -1;
      end else if (m_hold == 7) begin
        m_start = m_owner + 1;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
      m_gnt = 4'b0001;
      m_gnt = (m_owner < 0) ? 4'b0000 : (m_gnt << m_owner);
      tick();
      if (gnt !== m_gnt || timeout !== m_to || !$onehot0(gnt) || gnt_valid !== (|gnt)
          || (m_owner >= 0 && gnt_id !== 2'(m_owner))) bad++;
    end
    done = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL soak_model: %0d mismatching cycles, want 0", bad);
    end
    n_checks++;
    if (onehot_err !== 1'b0) begin
      n_errors++;
      $display("FAIL soak_onehot_err: onehot_err=%b, want 0", onehot_err);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_masked_skip();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    test_soak();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
